// File: rtl/sccb_master_pkg.sv
// Shared encodings for the SCCB master: bus codes, register map, symbol and FSM states.
package sccb_master_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned RESP_W = 2;

    localparam logic [CMD_W-1:0] MCMD_IDLE = 3'b000;
    localparam logic [CMD_W-1:0] MCMD_WR   = 3'b001;
    localparam logic [CMD_W-1:0] MCMD_RD   = 3'b010;

    localparam logic [RESP_W-1:0] SRESP_NULL = 2'b00;
    localparam logic [RESP_W-1:0] SRESP_DVA  = 2'b01;
    localparam logic [RESP_W-1:0] SRESP_ERR  = 2'b11;

    localparam logic [DATA_W-1:0] REG_CTRL     = 8'h00;
    localparam logic [DATA_W-1:0] REG_DEV_ID   = 8'h01;
    localparam logic [DATA_W-1:0] REG_SUB_ADDR = 8'h02;
    localparam logic [DATA_W-1:0] REG_WDATA    = 8'h03;
    localparam logic [DATA_W-1:0] REG_RDATA    = 8'h04;
    localparam logic [DATA_W-1:0] REG_CLKDIV   = 8'h05;

    // One SCCB symbol, four quarters long
    typedef enum logic [2:0] {
        SYM_GAP   = 3'd0,
        SYM_START = 3'd1,
        SYM_STOP  = 3'd2,
        SYM_TX    = 3'd3,
        SYM_RX    = 3'd4
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_NINTH = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // A divider of zero behaves like one
    function automatic logic [DATA_W-1:0] eff_div(input logic [DATA_W-1:0] div);
        return (div == '0) ? 8'd1 : div;
    endfunction

endpackage

// File: rtl/sccb_master_bit_engine.sv
// Quarter-bit divider and symbol generator; accepts a new symbol on the cycle its predecessor finishes.
module sccb_bit_engine
    import sccb_master_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] qdiv,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_sym,
    input  logic       cmd_bit,
    output logic       done_c,
    output logic       rx_bit,
    output logic       sio_c,
    output logic       sio_d_o,
    output logic       sio_d_oe,
    input  logic       sio_d_i
);

    logic       active;
    logic [7:0] cnt;
    logic [1:0] q;
    logic [2:0] sym;
    logic       tx_bit;
    logic [7:0] div_eff;
    logic       tick;
    logic       c_n;
    logic       d_n;
    logic       oe_n;

    assign div_eff = eff_div(qdiv);
    assign tick    = (cnt == div_eff - 8'd1);
    assign done_c  = active && tick && (q == 2'd3);

    // Line levels for the current symbol and quarter
    always_comb begin
        c_n  = 1'b1;
        d_n  = 1'b1;
        oe_n = 1'b0;
        if (active) begin
            case (sym)
                SYM_START: begin
                    c_n  = (q <= 2'd1);
                    d_n  = (q == 2'd0);
                    oe_n = 1'b1;
                end
                SYM_STOP: begin
                    c_n  = (q != 2'd0);
                    d_n  = (q >= 2'd2);
                    oe_n = (q <= 2'd1);
                end
                SYM_TX: begin
                    c_n  = (q == 2'd1) || (q == 2'd2);
                    d_n  = tx_bit;
                    oe_n = 1'b1;
                end
                SYM_RX: begin
                    c_n  = (q == 2'd1) || (q == 2'd2);
                end
                default: ;
            endcase
        end
    end

    // Divider, quarter sequencing, read sampling and registered pad drive
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            cnt      <= '0;
            q        <= '0;
            sym      <= SYM_GAP;
            tx_bit   <= 1'b1;
            rx_bit   <= 1'b0;
            sio_c    <= 1'b1;
            sio_d_o  <= 1'b1;
            sio_d_oe <= 1'b0;
        end else begin
            if (!active || done_c) begin
                cnt    <= '0;
                q      <= '0;
                active <= cmd_valid;
                if (cmd_valid) begin
                    sym    <= cmd_sym;
                    tx_bit <= cmd_bit;
                end
            end else if (tick) begin
                cnt <= '0;
                q   <= q + 2'd1;
                if ((q == 2'd1) && (sym == SYM_RX)) begin
                    rx_bit <= sio_d_i;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
            sio_c    <= c_n;
            sio_d_o  <= d_n;
            sio_d_oe <= oe_n;
        end
    end

endmodule

// File: rtl/sccb_master.sv
// SCCB register-access master: OCP-style register file plus byte sequencer driving the bit engine.
module sccb_master
    import sccb_master_pkg::*;
#(
    parameter int unsigned QDIV_DEFAULT  = 120,
    parameter logic [7:0]  DEVID_DEFAULT = 8'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sccb_MCmd,
    input  logic [7:0] sccb_MAddr,
    input  logic [7:0] sccb_MData,
    output logic       sccb_SCmdAccept,
    output logic [7:0] sccb_SData,
    output logic [1:0] sccb_SResp,
    output logic       sio_c,
    output logic       sio_d_o,
    output logic       sio_d_oe,
    input  logic       sio_d_i,
    output logic       busy
);

    state_t     state, state_n;
    logic [7:0] dev_id, sub_addr, wdata, rdata, clkdiv, shreg, rd_mux;
    logic       nack;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] byte_idx, byte_idx_n;
    logic       second, second_n, is_read, is_read_n;
    logic       addr_ok_c, wr_ok_c, start_wr_c, start_rd_c;
    logic       eng_valid_c, eng_bit_c, eng_done_c, eng_rx;
    logic [2:0] eng_sym_c;
    logic       issue_bit_c, set_nack_c, clr_nack_c, shift_en_c, rdata_load_c;
    logic       rx_byte_c, last_byte_c;
    logic [7:0] sel_byte_c;

    assign sccb_SCmdAccept = (sccb_MCmd != MCMD_IDLE);

    // Command decode: which writes take effect and which start a transaction
    always_comb begin
        addr_ok_c  = (sccb_MAddr <= REG_CLKDIV);
        wr_ok_c    = (sccb_MCmd == MCMD_WR) && addr_ok_c && (sccb_MAddr != REG_RDATA) && !busy
                     && !((sccb_MAddr == REG_CTRL) && (sccb_MData[1:0] == 2'b11));
        start_wr_c = wr_ok_c && (sccb_MAddr == REG_CTRL) && (sccb_MData[1:0] == 2'b01);
        start_rd_c = wr_ok_c && (sccb_MAddr == REG_CTRL) && (sccb_MData[1:0] == 2'b10);
    end

    // Read-data mux
    always_comb begin
        rd_mux = '0;
        case (sccb_MAddr)
            REG_CTRL:     rd_mux = {6'b0, nack, busy};
            REG_DEV_ID:   rd_mux = dev_id;
            REG_SUB_ADDR: rd_mux = sub_addr;
            REG_WDATA:    rd_mux = wdata;
            REG_RDATA:    rd_mux = rdata;
            REG_CLKDIV:   rd_mux = clkdiv;
            default:      rd_mux = '0;
        endcase
    end

    // One-cycle registered response to every accepted command
    always_ff @(posedge clk) begin
        if (reset) begin
            sccb_SResp <= SRESP_NULL;
            sccb_SData <= '0;
        end else begin
            sccb_SResp <= SRESP_NULL;
            sccb_SData <= '0;
            if (sccb_MCmd == MCMD_RD) begin
                sccb_SResp <= addr_ok_c ? SRESP_DVA : SRESP_ERR;
                sccb_SData <= addr_ok_c ? rd_mux : 8'h00;
            end else if (sccb_MCmd == MCMD_WR) begin
                sccb_SResp <= wr_ok_c ? SRESP_DVA : SRESP_ERR;
            end else if (sccb_MCmd != MCMD_IDLE) begin
                sccb_SResp <= SRESP_ERR;
            end
        end
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_id   <= DEVID_DEFAULT;
            sub_addr <= '0;
            wdata    <= '0;
            clkdiv   <= 8'(QDIV_DEFAULT);
        end else if (wr_ok_c) begin
            case (sccb_MAddr)
                REG_DEV_ID:   dev_id   <= sccb_MData;
                REG_SUB_ADDR: sub_addr <= sccb_MData;
                REG_WDATA:    wdata    <= sccb_MData;
                REG_CLKDIV:   clkdiv   <= sccb_MData;
                default: ;
            endcase
        end
    end

    // Sequencer next state and the symbol handed to the engine
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        byte_idx_n   = byte_idx;
        second_n     = second;
        is_read_n    = is_read;
        eng_valid_c  = 1'b0;
        eng_sym_c    = SYM_GAP;
        eng_bit_c    = 1'b1;
        issue_bit_c  = 1'b0;
        set_nack_c   = 1'b0;
        clr_nack_c   = 1'b0;
        shift_en_c   = 1'b0;
        rdata_load_c = 1'b0;
        rx_byte_c    = second && (byte_idx == 2'd1);
        last_byte_c  = (second || is_read) ? (byte_idx == 2'd1) : (byte_idx == 2'd2);

        case (state)
            ST_IDLE: begin
                if (start_wr_c || start_rd_c) begin
                    state_n     = ST_START;
                    second_n    = 1'b0;
                    is_read_n   = start_rd_c;
                    byte_idx_n  = '0;
                    clr_nack_c  = 1'b1;
                    eng_valid_c = 1'b1;
                    eng_sym_c   = SYM_START;
                end
            end
            ST_START: begin
                if (eng_done_c) begin
                    state_n     = ST_BYTE;
                    byte_idx_n  = '0;
                    bit_cnt_n   = '0;
                    issue_bit_c = 1'b1;
                end
            end
            ST_BYTE: begin
                if (eng_done_c) begin
                    shift_en_c = rx_byte_c;
                    if (bit_cnt == 3'd7) begin
                        state_n      = ST_NINTH;
                        eng_valid_c  = 1'b1;
                        rdata_load_c = rx_byte_c;
                        eng_sym_c    = rx_byte_c ? SYM_TX : SYM_RX;
                    end else begin
                        bit_cnt_n   = bit_cnt + 3'd1;
                        issue_bit_c = 1'b1;
                    end
                end
            end
            ST_NINTH: begin
                if (eng_done_c) begin
                    set_nack_c = !rx_byte_c && eng_rx;
                    if (last_byte_c) begin
                        state_n     = ST_STOP;
                        eng_valid_c = 1'b1;
                        eng_sym_c   = SYM_STOP;
                    end else begin
                        state_n     = ST_BYTE;
                        byte_idx_n  = byte_idx + 2'd1;
                        bit_cnt_n   = '0;
                        issue_bit_c = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (eng_done_c) begin
                    if (is_read && !second) begin
                        state_n     = ST_GAP;
                        second_n    = 1'b1;
                        eng_valid_c = 1'b1;
                        eng_sym_c   = SYM_GAP;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (eng_done_c) begin
                    state_n     = ST_START;
                    eng_valid_c = 1'b1;
                    eng_sym_c   = SYM_START;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Byte on the wire for the bit about to be issued
        if (second_n)
            sel_byte_c = dev_id | 8'h01;
        else if (byte_idx_n == 2'd0)
            sel_byte_c = dev_id & 8'hFE;
        else if (byte_idx_n == 2'd1)
            sel_byte_c = sub_addr;
        else
            sel_byte_c = wdata;

        if (issue_bit_c) begin
            eng_valid_c = 1'b1;
            eng_sym_c   = (second_n && (byte_idx_n == 2'd1)) ? SYM_RX : SYM_TX;
            eng_bit_c   = sel_byte_c[3'd7 - bit_cnt_n];
        end
    end

    // Sequencer state, status and received data
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            second   <= 1'b0;
            is_read  <= 1'b0;
            busy     <= 1'b0;
            nack     <= 1'b0;
            shreg    <= '0;
            rdata    <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            byte_idx <= byte_idx_n;
            second   <= second_n;
            is_read  <= is_read_n;
            busy     <= (state_n != ST_IDLE);
            if (clr_nack_c)
                nack <= 1'b0;
            else if (set_nack_c)
                nack <= 1'b1;
            if (shift_en_c)
                shreg <= {shreg[6:0], eng_rx};
            if (rdata_load_c)
                rdata <= {shreg[6:0], eng_rx};
        end
    end

    sccb_bit_engine u_engine (
        .clk       (clk),
        .reset     (reset),
        .qdiv      (clkdiv),
        .cmd_valid (eng_valid_c),
        .cmd_sym   (eng_sym_c),
        .cmd_bit   (eng_bit_c),
        .done_c    (eng_done_c),
        .rx_bit    (eng_rx),
        .sio_c     (sio_c),
        .sio_d_o   (sio_d_o),
        .sio_d_oe  (sio_d_oe),
        .sio_d_i   (sio_d_i)
    );

endmodule

// File: doc/sccb_master.md
Name: sccb_master

Overview:
- OCP-style slave on the tree_link bus; the register-access path for configuring the camera sensor over SCCB (SIO_C/SIO_D).
- The host writes the device ID, sub-address and data through the UART transaction path, triggers a 3-phase write or a 2+2-phase read, then polls status and read data.
- Sits beside line_buffer, downstream of tree_link. SIO_D tristate/pad is instantiated at top.

Parameters:
- QDIV_DEFAULT, 120: reset value of CLKDIV; clk cycles per quarter SCL bit (100 kHz SCL at 48 MHz).
- DEVID_DEFAULT, 8'h42: reset value of DEV_ID (sensor write address; bit0 ignored).

Ports:
- clk  in  1  system clock (mclk domain)
- reset  in  1  synchronous reset, active-high
- sccb_MCmd  in  3  3'b000 IDLE, 3'b001 WR, 3'b010 RD; other codes are treated as an illegal command
- sccb_MAddr  in  8  register address
- sccb_MData  in  8  write data
- sccb_SCmdAccept  out  1  command accepted
- sccb_SData  out  8  read data
- sccb_SResp  out  2  2'b00 NULL, 2'b01 DVA, 2'b11 ERR
- sio_c  out  1  SCCB clock
- sio_d_o  out  1  SIO_D drive value
- sio_d_oe  out  1  1 = drive sio_d_o, 0 = release (pull-up)
- sio_d_i  in  1  SIO_D pad input
- busy  out  1  transaction in progress (for a debugger LED)

Behaviour:
- Reset (sync, high): SCmdAccept=0, SResp=NULL, SData=0, sio_c=1, sio_d_oe=0, sio_d_o=1, busy=0, FSM=IDLE, CLKDIV=QDIV_DEFAULT, DEV_ID=DEVID_DEFAULT, other regs 0. A reset during a transaction aborts it; lines are released on the next edge with no STOP generated.
- Bus handshake:
  - SCmdAccept = (MCmd != IDLE), combinational, so every command is accepted in the cycle it is presented.
  - SResp/SData are registered and valid exactly 1 cycle after acceptance, for 1 cycle; otherwise SResp=NULL and SData=0.
- Register map:
  - 0x00 CTRL/STAT. Write: bit0=start write, bit1=start read; both set gives ERR. Read: {6'b0, nack, busy}.
  - 0x01 DEV_ID, RW.
  - 0x02 SUB_ADDR, RW.
  - 0x03 WDATA, RW.
  - 0x04 RDATA, RO.
  - 0x05 CLKDIV, RW. Value 0 is treated as 1.
- ERR responses (write ignored): unmapped address; illegal MCmd; write to 0x04; any write to 0x00–0x03 or 0x05 while busy. Reads while busy return DVA.
- Writing CTRL with bits=0 gives DVA with no effect.
- Quarter tick: counter counts to CLKDIV-1 then wraps; each SCCB symbol is 4 quarters q0..q3. The counter restarts at 0 on start.
- FSM: IDLE → START → BYTE (8 bits MSB first) → NINTH → ... → STOP → IDLE. A read inserts GAP (4 idle quarters) and then a second START.
- START: q0 c=1,d=1; q1 c=1,d=0; q2–q3 c=0,d=0.
- Data bit: q0 c=0 with data driven; q1–q2 c=1; q3 c=0. The read bit is sampled from sio_d_i at the end of q1.
- STOP: q0 c=0,d=0; q1 c=1,d=0; q2–q3 c=1,d released.
- Write sequence: START, DEV_ID&8'hFE, SUB_ADDR, WDATA, STOP = 116 quarters.
- Read sequence: START, DEV_ID&FE, SUB_ADDR, STOP, GAP, START, DEV_ID|1, 8 data bits (oe=0), ninth bit NA driven 1, STOP = 164 quarters. RDATA is updated at the end of the 8th data bit.
- Ninth bit after a master-sent byte: oe=0; sio_d_i is sampled at the end of q1; a 1 sets nack (sticky until the next start). The transaction always continues, since SCCB treats this bit as don't-care.
- busy rises the cycle after the accepted start write and falls the cycle after STOP q3 ends. Total busy time is quarters×CLKDIV cycles, ±1.
- A CLKDIV change while busy is rejected (ERR), so timing is stable within a transaction.

Decomposition:
- Shared include sccb_defs.vh: MCmd/SResp encodings, register address constants, FSM state encodings.
- One sub-module, sccb_bit_engine: quarter divider plus symbol generator. Command in: START/STOP/TXBIT/RXBIT/GAP with data. Outputs: done pulse, rx bit, sio lines. The top-level FSM and register file sequence the bytes.

Test Plan:
- Reset, read 0x01/0x05/0x00 → DVA with 8'h42 / 8'd120 / 8'h00; sio_c=1, sio_d_oe=0.
- CLKDIV=2, DEV_ID=0x42, SUB=0x12, WDATA=0x80, CTRL=0x01 → SIO bit stream 0x42,Z,0x12,Z,0x80,Z with START/STOP; busy for 232±1 cycles; STAT then reads 0x00 (slave model ACKs).
- CLKDIV=2, SUB=0x0A, CTRL=0x02, slave returns 0x76 → byte 0x43 after restart, NA=1, RDATA reads 0x76, busy for 328±1 cycles.
- Write WDATA during busy → ERR, WDATA unchanged. Read 0x07 → ERR. Write 0x04 → ERR. CTRL=0x03 → ERR, no transaction starts.
- Slave leaves the ninth bit high → transaction completes fully; STAT bit1=1; the next start clears it.
- Assert reset mid-byte → next cycle sio_c=1, sio_d_oe=0, busy=0, SResp=NULL; a new write afterwards completes normally.
